public_sram_responder_ysyx23060136: RTL and testbench

PUBLIC_SRAM_RESPONDER_YSYX23060136 -- requirements
Module: PUBLIC_SRAM_RESPONDER_ysyx23060136

---
 rtl/public_sram_responder_ysyx23060136.sv | 83 ++++++++
 tb/tb_public_sram_responder_ysyx23060136.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/public_sram_responder_ysyx23060136.sv
// public_sram_responder_ysyx23060136: word SRAM behind a valid/ready read channel with fixed latency
// and an always-on byte-strobed write port.
module public_sram_responder_ysyx23060136 #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] SRAM_raddr,
  input  logic        SRAM_raddr_valid,
  output logic        SRAM_raddr_ready,
  output logic [31:0] SRAM_rdata,
  output logic        SRAM_rresp,
  output logic        SRAM_rdata_valid,
  input  logic        SRAM_rdata_ready,
  input  logic        SRAM_wen,
  input  logic [31:0] SRAM_waddr,
  input  logic [31:0] SRAM_wdata,
  input  logic [3:0]  SRAM_wstrb
);
  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT   = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, next;

  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic        alive;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_addr, rd_off, wr_off;
  logic        rd_hit, wr_hit, hs, enter_resp;

  assign SRAM_raddr_ready = state == IDLE && alive;
  assign SRAM_rdata_valid = state == RESP;

  always_comb begin
    hs = SRAM_raddr_valid && SRAM_raddr_ready;
    next = (state == IDLE && hs) ? (LAT == 4'd0 ? RESP : WAIT)
         : (state == WAIT && cnt <= 4'd1) ? RESP
         : (state == RESP && SRAM_rdata_ready) ? IDLE
         : state;
    enter_resp = next == RESP && state != RESP;
    // with zero latency the read is issued straight from the handshake address
    rd_addr = state == IDLE ? SRAM_raddr : addr_q;
    rd_off = rd_addr - BASE_ADDR;
    rd_hit = rd_off < LIMIT;
    wr_off = SRAM_waddr - BASE_ADDR;
    wr_hit = wr_off < LIMIT;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;

  // alive delays raddr_ready by one edge after reset release
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      alive <= 1'b0;
      cnt <= 4'd0;
      addr_q <= 32'h0;
      SRAM_rdata <= 32'h0;
      SRAM_rresp <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (hs) begin
        addr_q <= SRAM_raddr;
        cnt <= LAT;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (enter_resp) begin
        SRAM_rdata <= rd_hit ? mem[rd_off[AW+1:2]] : 32'hDEAD_BEEF;
        SRAM_rresp <= !rd_hit;
      end
    end

  // storage has no reset; a write on the RESP-entry edge lands after the read sample
  always_ff @(posedge clk)
    if (SRAM_wen && wr_hit)
      for (int i = 0; i < 4; i++)
        if (SRAM_wstrb[i]) mem[wr_off[AW+1:2]][8*i +: 8] <= SRAM_wdata[8*i +: 8];
endmodule

// File: tb/tb_public_sram_responder_ysyx23060136.sv
// tb_public_sram_responder_ysyx23060136: table vectors, corner sequences and random reads
// against a word-array model, on a LATENCY=2 and a LATENCY=0 instance.
module tb_public_sram_responder_ysyx23060136;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 1024;

  logic clk = 1'b0, rst = 1'b0;
  logic [31:0] raddr [2];
  logic rv [2], rr [2], ready_o [2], valid_o [2], rresp_o [2];
  logic [31:0] rdata_o [2];
  logic wen = 1'b0;
  logic [31:0] waddr = 32'h0, wdata = 32'h0;
  logic [3:0] wstrb = 4'h0;
  int lat_of [2] = '{2, 0};
  int n_vec = 0, n_bad = 0;
  logic [31:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  public_sram_responder_ysyx23060136 #(.LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .SRAM_raddr(raddr[0]), .SRAM_raddr_valid(rv[0]),
    .SRAM_raddr_ready(ready_o[0]), .SRAM_rdata(rdata_o[0]), .SRAM_rresp(rresp_o[0]),
    .SRAM_rdata_valid(valid_o[0]), .SRAM_rdata_ready(rr[0]), .SRAM_wen(wen),
    .SRAM_waddr(waddr), .SRAM_wdata(wdata), .SRAM_wstrb(wstrb));

  public_sram_responder_ysyx23060136 #(.LATENCY(0)) dut1 (
    .clk(clk), .rst(rst), .SRAM_raddr(raddr[1]), .SRAM_raddr_valid(rv[1]),
    .SRAM_raddr_ready(ready_o[1]), .SRAM_rdata(rdata_o[1]), .SRAM_rresp(rresp_o[1]),
    .SRAM_rdata_valid(valid_o[1]), .SRAM_rdata_ready(rr[1]), .SRAM_wen(wen),
    .SRAM_waddr(waddr), .SRAM_wdata(wdata), .SRAM_wstrb(wstrb));

  typedef struct {
    logic        wr;
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    logic [31:0] ra, exp_d;
    logic        exp_r;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return off < WORDS * 4 ? ref_mem[off / 4] : 32'hDEAD_BEEF;
  endfunction

  task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] off = a - BASE;
    if (off < WORDS * 4)
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[off / 4][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    wen = 1'b1; waddr = a; wdata = d; wstrb = s;
    @(negedge clk);
    wen = 1'b0;
    ref_write(a, d, s);
  endtask

  // wr_edge: edge index after the handshake edge (0 = handshake edge) on which a write lands, -1 none
  task automatic rd(input int d, input logic [31:0] a, input int wr_edge, input logic [31:0] wa,
                    input logic [31:0] wd, input logic [3:0] ws, input logic [31:0] exp_d,
                    input logic exp_r, input string nm);
    int k = 0, n = 0;
    @(negedge clk);
    raddr[d] = a; rv[d] = 1'b1; rr[d] = 1'b0;
    while (!ready_o[d] && k < 50) begin @(negedge clk); k++; end
    if (k == 50) begin chk({nm, "_ready_timeout"}, 32'(ready_o[d]), 32'h1); rv[d] = 1'b0; return; end
    do begin
      if (n == wr_edge) begin wen = 1'b1; waddr = wa; wdata = wd; wstrb = ws; end
      @(negedge clk);
      wen = 1'b0; rv[d] = 1'b0; n++;
    end while (!valid_o[d] && n < 40);
    chk({nm, "_latency"}, 32'(n), 32'(lat_of[d] + 1));
    chk({nm, "_rdata"}, rdata_o[d], exp_d);
    chk({nm, "_rresp"}, 32'(rresp_o[d]), 32'(exp_r));
    rr[d] = 1'b1;
    @(negedge clk);
    rr[d] = 1'b0;
    chk({nm, "_valid_drop"}, 32'(valid_o[d]), 32'h0);
    chk({nm, "_ready_back"}, 32'(ready_o[d]), 32'h1);
  endtask

  initial begin
    logic [31:0] a, e, wa, wd;
    logic [3:0] ws;
    int d, we, r;
    for (int i = 0; i < 2; i++) begin raddr[i] = 32'h0; rv[i] = 1'b0; rr[i] = 1'b0; end
    tbl[0] = '{1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF, 32'h8000_0010, 32'h1234_5678, 1'b0};
    tbl[1] = '{1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0010, 32'h8000_0010, 32'h1234_CC78, 1'b0};
    tbl[2] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h8000_0013, 32'h1234_CC78, 1'b0};
    tbl[3] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h7FFF_FFFC, 32'hDEAD_BEEF, 1'b1};
    tbl[4] = '{1'b0, 32'h0, 32'h0, 4'h0, 32'h8000_1000, 32'hDEAD_BEEF, 1'b1};
    tbl[5] = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0};
    tbl[6] = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 32'h8000_0FFC, 32'hCAFE_F00D, 1'b0};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(ready_o[i]), 32'h0);
      chk("rst_valid", 32'(valid_o[i]), 32'h0);
      chk("rst_rdata", rdata_o[i], 32'h0);
      chk("rst_rresp", 32'(rresp_o[i]), 32'h0);
    end
    rst = 1'b1;
    #1 chk("release_ready_before_edge", 32'(ready_o[0]), 32'h0);
    @(negedge clk);
    chk("release_ready_first_edge", 32'(ready_o[0]), 32'h1);

    for (int i = 0; i < WORDS; i++) wr(BASE + 32'(i * 4), $urandom, 4'hF);

    foreach (tbl[i]) begin
      if (tbl[i].wr) wr(tbl[i].wa, tbl[i].wd, tbl[i].ws);
      rd(0, tbl[i].ra, -1, 0, 0, 0, tbl[i].exp_d, tbl[i].exp_r, $sformatf("tbl%0d", i));
    end

    // write landing on the RESP-entry edge is not seen; one edge earlier it is
    e = ref_read(32'h8000_0020);
    rd(0, 32'h8000_0020, 2, 32'h8000_0020, 32'h0BAD_F00D, 4'hF, e, 1'b0, "same_edge_l2");
    ref_write(32'h8000_0020, 32'h0BAD_F00D, 4'hF);
    rd(0, 32'h8000_0020, 1, 32'h8000_0020, 32'h1111_2222, 4'hF, 32'h1111_2222, 1'b0, "early_edge_l2");
    ref_write(32'h8000_0020, 32'h1111_2222, 4'hF);
    e = ref_read(32'h8000_0024);
    rd(1, 32'h8000_0024, 0, 32'h8000_0024, 32'h3333_4444, 4'hF, e, 1'b0, "same_edge_l0");
    ref_write(32'h8000_0024, 32'h3333_4444, 4'hF);
    rd(1, 32'h8000_0024, -1, 0, 0, 0, 32'h3333_4444, 1'b0, "after_write_l0");

    // stalled response: data held, no new address accepted, second request not buffered
    e = ref_read(32'h8000_0010);
    @(negedge clk);
    raddr[0] = 32'h8000_0010; rv[0] = 1'b1; rr[0] = 1'b0;
    r = 0;
    while (!ready_o[0] && r < 50) begin @(negedge clk); r++; end
    @(negedge clk);
    raddr[0] = 32'h8000_0040;
    r = 0;
    while (!valid_o[0] && r < 20) begin @(negedge clk); r++; end
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(valid_o[0]), 32'h1);
      chk("stall_rdata", rdata_o[0], e);
      chk("stall_ready", 32'(ready_o[0]), 32'h0);
      @(negedge clk);
    end
    rv[0] = 1'b0; rr[0] = 1'b1;
    @(negedge clk);
    rr[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_no_second", 32'(valid_o[0]), 32'h0);
      @(negedge clk);
    end

    // zero latency, back-to-back: handshakes alternate with response cycles
    e = ref_read(32'h8000_0100);
    raddr[1] = 32'h8000_0100; rv[1] = 1'b1; rr[1] = 1'b1;
    r = 0;
    while (!ready_o[1] && r < 50) begin @(negedge clk); r++; end
    for (int i = 0; i < 6; i++) begin
      chk("b2b_ready", 32'(ready_o[1]), 32'(i % 2 == 0));
      chk("b2b_valid", 32'(valid_o[1]), 32'(i % 2 == 1));
      if (i % 2 == 1) chk("b2b_rdata", rdata_o[1], e);
      @(negedge clk);
    end
    rv[1] = 1'b0; rr[1] = 1'b0;
    @(negedge clk);

    // reset while waiting aborts the read
    raddr[0] = 32'h8000_0010; rv[0] = 1'b1;
    r = 0;
    while (!ready_o[0] && r < 50) begin @(negedge clk); r++; end
    @(negedge clk);
    rv[0] = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(valid_o[0]), 32'h0);
    chk("abort_ready", 32'(ready_o[0]), 32'h0);
    chk("abort_rdata", rdata_o[0], 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(valid_o[0]), 32'h0);
      chk("abort_ready_back", 32'(ready_o[0]), 32'h1);
    end

    for (int t = 0; t < 80; t++) begin
      d = int'($urandom_range(1, 0));
      r = int'($urandom_range(9, 0));
      a = r < 7 ? BASE + $urandom_range(WORDS * 4 - 1, 0)
        : r == 7 ? BASE + WORDS * 4 + $urandom_range(15, 0)
        : r == 8 ? BASE - 1 - $urandom_range(15, 0) : $urandom;
      we = int'($urandom_range(3, 0)) - 1;
      if (we > lat_of[d]) we = -1;
      wa = $urandom_range(1, 0) ? a : BASE + $urandom_range(WORDS * 4 - 1, 0);
      wd = $urandom;
      ws = 4'($urandom);
      if (we >= 0 && we < lat_of[d]) ref_write(wa, wd, ws);
      e = ref_read(a);
      rd(d, a, we, wa, wd, ws, e, e == 32'hDEAD_BEEF && (a - BASE) >= WORDS * 4,
         $sformatf("rand%0d", t));
      if (we >= lat_of[d]) ref_write(wa, wd, ws);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
